// File: rtl/en_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : en_pulse_pkg
// Description : Shared types and constants for the debounced enable generator.
// Revision    : 1.0
// ============================================================================
package en_pulse_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } en_state_t;

    localparam int DB_CYCLES_DEFAULT = 4;

endpackage : en_pulse_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous level input.
// Revision    : 1.0
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/en_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : en_pulse_gen
// Description : Debounces a raw level and emits a clean level plus one-cycle
//               rise/fall enable pulses.
// Revision    : 1.0
// ============================================================================
module en_pulse_gen
    import en_pulse_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic db_level,
    output logic en_rise,
    output logic en_fall
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_s2;
    en_state_t        r_state;
    en_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Outputs are computed one cycle ahead so that level and pulses are registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s2) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = ST_HIGH;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_HIGH;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (!w_s2) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_HIGH: begin
                if (!w_s2) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = ST_LOW;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_LOW;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (w_s2) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign db_level = r_level;
    assign en_rise  = r_rise;
    assign en_fall  = r_fall;

endmodule : en_pulse_gen
`default_nettype wire

// File: tb/tb_en_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_en_pulse_gen
// Description : Directed self-checking bench for en_pulse_gen with DB_CYCLES=4.
// Revision    : 1.0
// ============================================================================
module tb_en_pulse_gen;
    import en_pulse_pkg::*;

    logic clk;
    logic rst;
    logic din;
    logic db_level;
    logic en_rise;
    logic en_fall;

    int errors;
    int checks;

    en_pulse_gen #(.DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .db_level (db_level),
        .en_rise  (en_rise),
        .en_fall  (en_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({db_level, en_rise, en_fall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b%b%b expected 000", i, db_level, en_rise, en_fall);
            end
        end
        rst = 1'b0;
        // edge 0 is the first post-reset sample; the pulse follows edge 5
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (en_rise !== (i == 5)) begin
                errors++;
                $display("FAIL reset_release_rise edge %0d: got %b expected %b", i, en_rise, (i == 5));
            end
        end
        checks++;
        if (db_level !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_level: got %b expected 1", db_level);
        end
    endtask

    task automatic test_clean_fall();
        din = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (en_fall !== (i == 5) || en_rise !== 1'b0 || db_level !== (i < 5)) begin
                errors++;
                $display("FAIL clean_fall edge %0d: got lvl=%b rise=%b fall=%b expected lvl=%b rise=0 fall=%b",
                         i, db_level, en_rise, en_fall, (i < 5), (i == 5));
            end
        end
    endtask

    task automatic test_clean_rise();
        din = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (en_rise !== (i == 5) || en_fall !== 1'b0 || db_level !== (i >= 5)) begin
                errors++;
                $display("FAIL clean_rise edge %0d: got lvl=%b rise=%b fall=%b expected lvl=%b rise=%b fall=0",
                         i, db_level, en_rise, en_fall, (i >= 5), (i == 5));
            end
        end
    endtask

    task automatic test_glitch();
        din = 1'b0;
        repeat (10) step();
        for (int i = 0; i < 14; i++) begin
            din = (i < 3) ? 1'b1 : 1'b0;
            step();
            checks++;
            if ({db_level, en_rise, en_fall} !== 3'b000) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b%b%b expected 000", i, db_level, en_rise, en_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1111011;  // applied LSB first: 1,1,0,1,1,1,1
        for (int i = 0; i < 15; i++) begin
            din = (i < 7) ? pat[i] : 1'b1;
            step();
            checks++;
            if (en_rise !== (i == 8) || en_fall !== 1'b0) begin
                errors++;
                $display("FAIL bounce edge %0d: got rise=%b fall=%b expected rise=%b fall=0",
                         i, en_rise, en_fall, (i == 8));
            end
        end
        checks++;
        if (db_level !== 1'b1) begin
            errors++;
            $display("FAIL bounce_level: got %b expected 1", db_level);
        end
    endtask

    task automatic test_reset_mid_wait();
        din = 1'b0;
        repeat (10) step();
        din = 1'b1;
        repeat (4) step();  // edges 0..3: WAIT_HIGH entered at edge 2, cnt=2 after edge 3
        checks++;
        if (dut.r_state !== ST_WAIT_HIGH) begin
            errors++;
            $display("FAIL mid_wait_pre_state: got %0d expected %0d", dut.r_state, ST_WAIT_HIGH);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dut.r_state !== ST_LOW || dut.r_cnt !== 2'd0 || {db_level, en_rise, en_fall} !== 3'b000) begin
            errors++;
            $display("FAIL mid_wait_reset: got state=%0d cnt=%0d out=%b%b%b expected state=0 cnt=0 out=000",
                     dut.r_state, dut.r_cnt, db_level, en_rise, en_fall);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (en_rise !== (i == 5) || en_fall !== 1'b0) begin
                errors++;
                $display("FAIL mid_wait_reaccept edge %0d: got rise=%b fall=%b expected rise=%b fall=0",
                         i, en_rise, en_fall, (i == 5));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        din    = 1'b0;
        test_reset();
        test_clean_fall();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_en_pulse_gen
`default_nettype wire
